// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: op encodings, bus widths, arbiter FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package lcd_pkg;

    localparam int LCD_OP_W   = 4;
    localparam int LCD_DATA_W = 8;

    // Executor op encodings
    localparam logic [LCD_OP_W-1:0] OP_CLEAR   = 4'd0;
    localparam logic [LCD_OP_W-1:0] OP_P1_GAME = 4'd1;
    localparam logic [LCD_OP_W-1:0] OP_P2_GAME = 4'd2;
    localparam logic [LCD_OP_W-1:0] OP_P1_SET  = 4'd3;
    localparam logic [LCD_OP_W-1:0] OP_P2_SET  = 4'd4;
    localparam logic [LCD_OP_W-1:0] OP_CURSOR  = 4'd5;
    localparam logic [LCD_OP_W-1:0] OP_CHAR    = 4'd6;
    localparam logic [LCD_OP_W-1:0] OP_NOP     = 4'd15;

    // Bus arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } arb_state_e;

endpackage

// File: rtl/lcd_bus_arbiter_rr_pick.sv
// Circular priority pick: first set bit of req at or after ptr, one-hot result plus valid.
// Latency: purely combinational.
// Backpressure: none; caller decides when to act on the pick.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   pick_rot;
    logic [2*N-1:0] gnt_dbl;

    // Rotate so bit 0 is the requester at ptr, pick lowest set bit, rotate back
    always_comb begin
        req_dbl  = {req, req} >> ptr;
        req_rot  = req_dbl[N-1:0];
        pick_rot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_rot    = '0;
                pick_rot[k] = 1'b1;
            end
        end
        gnt_dbl = {pick_rot, pick_rot} << ptr;
        gnt     = gnt_dbl[2*N-1:N];
        vld     = |req;
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one LCD executor between N_REQ command sources, with locked bursts.
// Latency: req seen in IDLE -> exe_en/ack visible two cycles later when exe_rdy is high.
// Backpressure: issue waits for exe_rdy high; each word completes on exe_rdy low->high (or LOW_WAIT bypass).
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int OP_W     = LCD_OP_W,
    parameter int DATA_W   = LCD_DATA_W,
    parameter int LOW_WAIT = 4,
    parameter int LOCK_TO  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         last,
    input  logic [N_REQ*OP_W-1:0]    op_in,
    input  logic [N_REQ*DATA_W-1:0]  data_in,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         grant,
    output logic [OP_W-1:0]          exe_op,
    output logic [DATA_W-1:0]        exe_data,
    output logic                     exe_en,
    input  logic                     exe_rdy,
    output logic                     busy,
    output logic                     err
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int LW_W  = $clog2(LOW_WAIT + 1);
    localparam int LT_W  = $clog2(LOCK_TO + 1);

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                lock_q, lock_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]     exe_op_q, exe_op_d;
    logic [DATA_W-1:0]   exe_data_q, exe_data_d;
    logic                exe_en_q, exe_en_d;
    logic                err_q, err_d;
    logic [LW_W-1:0]     low_cnt_q, low_cnt_d;
    logic [LT_W-1:0]     lock_cnt_q, lock_cnt_d;

    logic [N_REQ-1:0]    pick_gnt;
    logic                pick_vld;
    logic [PTR_W-1:0]    owner_idx;
    logic [OP_W-1:0]     owner_op;
    logic [DATA_W-1:0]   owner_data;
    logic                owner_last;
    logic                owner_req;
    logic [PTR_W-1:0]    next_ptr;
    logic                low_done;
    logic                lock_expire;

    rr_pick #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    // Decode the current owner and mux its word; derive release pointer and counter terminals
    always_comb begin
        owner_idx  = '0;
        owner_op   = '0;
        owner_data = '0;
        owner_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx  = PTR_W'(i);
                owner_op   = op_in[i*OP_W +: OP_W];
                owner_data = data_in[i*DATA_W +: DATA_W];
                owner_last = last[i];
            end
        end
        owner_req   = |(req & grant_q);
        next_ptr    = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
        low_done    = (low_cnt_q == LW_W'(LOW_WAIT - 1));
        lock_expire = (lock_cnt_q == LT_W'(LOCK_TO - 1));
    end

    // State and datapath registers; reset drops the bus and all strobes at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            lock_q     <= 1'b0;
            rr_ptr_q   <= '0;
            exe_op_q   <= '0;
            exe_data_q <= '0;
            exe_en_q   <= 1'b0;
            err_q      <= 1'b0;
            low_cnt_q  <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            lock_q     <= lock_d;
            rr_ptr_q   <= rr_ptr_d;
            exe_op_q   <= exe_op_d;
            exe_data_q <= exe_data_d;
            exe_en_q   <= exe_en_d;
            err_q      <= err_d;
            low_cnt_q  <= low_cnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next-state: arbitrate, issue on rdy, then follow the executor's rdy low/high handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lock_q) begin
                    if (owner_req) begin
                        state_d = ST_ISSUE;
                    end
                end else if (pick_vld) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (exe_rdy) begin
                    state_d = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                // An executor that finishes too fast to show rdy low is bypassed after LOW_WAIT cycles
                if (!exe_rdy || low_done) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (exe_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and bookkeeping: grant/lock/pointer updates, issue strobes, timeout counters
    always_comb begin
        grant_d    = grant_q;
        ack_d      = '0;
        lock_d     = lock_q;
        rr_ptr_d   = rr_ptr_q;
        exe_op_d   = exe_op_q;
        exe_data_d = exe_data_q;
        exe_en_d   = 1'b0;
        err_d      = err_q;
        low_cnt_d  = '0;
        lock_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (lock_q) begin
                    // Owner went quiet mid-burst: count idle cycles and force release at LOCK_TO
                    if (!owner_req) begin
                        if (lock_expire) begin
                            grant_d  = '0;
                            lock_d   = 1'b0;
                            rr_ptr_d = next_ptr;
                            err_d    = 1'b1;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                        end
                    end
                end else if (pick_vld) begin
                    grant_d = pick_gnt;
                end
            end
            ST_ISSUE: begin
                if (exe_rdy) begin
                    exe_op_d   = owner_op;
                    exe_data_d = owner_data;
                    exe_en_d   = 1'b1;
                    ack_d      = grant_q;
                    lock_d     = !owner_last;
                end
            end
            ST_WAIT_LOW: begin
                if (exe_rdy && !low_done) begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (exe_rdy && !lock_q) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: ;
        endcase
    end

    assign grant    = grant_q;
    assign ack      = ack_q;
    assign exe_op   = exe_op_q;
    assign exe_data = exe_data_q;
    assign exe_en   = exe_en_q;
    assign busy     = |grant_q;
    assign err      = err_q;

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the single LCD executor between several command sources, such as the score-update path, a banner/message writer and a clock/status writer. Each requester presents one {op, data} word at a time and may chain words into a locked burst, for example cursor-set followed by characters. The arbiter grants requesters round-robin, drives the executor's op/data/enable, and paces issue on the executor's `rdy` level. It sits between the command generators and the executor, replacing direct wiring of one generator to the executor.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `OP_W`, 4: executor op width.
- `DATA_W`, 8: executor data width.
- `LOW_WAIT`, 4: maximum cycles to wait for `exe_rdy` to fall after an issue.
- `LOCK_TO`, 1024: maximum idle cycles a locked requester may hold the bus without presenting a word.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-low reset.
- `req`  in  N_REQ  per-requester word valid.
- `last`  in  N_REQ  per-requester flag marking the final word of the burst.
- `op_in`  in  N_REQ*OP_W  packed ops; requester i occupies slice [i*OP_W +: OP_W].
- `data_in`  in  N_REQ*DATA_W  packed data, same slicing.
- `ack`  out  N_REQ  one-cycle pulse: the requester's word has been taken.
- `grant`  out  N_REQ  one-hot bus owner, or all zero.
- `exe_op`  out  OP_W  op to the executor.
- `exe_data`  out  DATA_W  data to the executor.
- `exe_en`  out  1  one-cycle issue strobe.
- `exe_rdy`  in  1  executor idle (level).
- `busy`  out  1  high whenever a grant is held.
- `err`  out  1  sticky flag: lock timeout occurred; cleared only by reset.

## Operation
FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE, unlocked:
  - If any `req` is high, pick the first requesting index at or after `rr_ptr` (circular).
  - Set `grant` to that index and enter ISSUE.
- IDLE, locked (`grant` held, previous word had `last`=0):
  - Only the owner is considered.
  - If the owner's `req` is high, enter ISSUE.
  - Other requests are ignored.
- ISSUE: wait for `exe_rdy`=1. When it is 1, in that same cycle:
  - register the owner's slices into `exe_op`/`exe_data`;
  - pulse `exe_en` and the owner's `ack`;
  - capture `last` into a lock bit (lock = !last);
  - go to WAIT_LOW.
- WAIT_LOW:
  - Leave for WAIT_HIGH when `exe_rdy`=0.
  - If `LOW_WAIT` cycles pass with `exe_rdy` still 1, the op is treated as already complete and the FSM goes to WAIT_HIGH.
- WAIT_HIGH: when `exe_rdy`=1, the word is complete.
  - If lock=1, return to IDLE-locked and keep the grant.
  - Otherwise clear `grant`, set `rr_ptr` = owner+1 (mod N_REQ), and return to IDLE.
- Lock timeout: a lock counter runs in IDLE-locked while the owner's `req`=0. When it reaches `LOCK_TO`:
  - force release, with `rr_ptr` advanced as for a normal release;
  - set `err`;
  - return to IDLE.
- `busy` = |`grant`.
- Requesters must hold `op_in`/`data_in`/`last` stable from `req` rising until `ack`.
- `exe_op`/`exe_data` hold their last value until the next issue.

## Timing
- Reset (async assert, sync release): `grant`=0, `ack`=0, `exe_en`=0, `exe_op`=0, `exe_data`=0, `busy`=0, `err`=0, `rr_ptr`=0, lock=0, FSM=IDLE.
- Latency with `exe_rdy`=1 throughout:
  - `req` is seen in IDLE at cycle 0;
  - ISSUE happens at cycle 1, with `exe_en` and `ack` registered and visible at cycle 2.
- Back-to-back words: at least 3 cycles between `exe_en` pulses (WAIT_LOW, WAIT_HIGH, IDLE→ISSUE).
- `exe_en` and `ack` are never high for two consecutive cycles.
- Simultaneous requests: round-robin order from `rr_ptr`; no requester is starved beyond N_REQ−1 bursts.
- A requester dropping `req` mid-burst keeps the bus until its next word or until the `LOCK_TO` timeout.
- Reset during WAIT_LOW/WAIT_HIGH returns to IDLE immediately; no `ack` or `exe_en` is issued while `rst`=0.
- `exe_rdy`=0 in IDLE does not block arbitration; issue is held in ISSUE.

## Structure
- Shared package `lcd_pkg`: the op encodings (clear, P1 game, P2 game, P1 set, P2 set, cursor, char, nop=15), `OP_W`/`DATA_W` defaults, and the FSM state constants.
- Sub-module `rr_pick`: combinational circular priority pick of `req` from `rr_ptr`, returning a one-hot result and a valid flag. Reused by future arbiters.
- All remaining logic (FSM, lock counter, LOW_WAIT counter) lives in `lcd_bus_arbiter`.

## Test plan
- Single requester: req0 sends a one-word burst (op=1, data=3, last=1) with `exe_rdy` model busy for 5 cycles → one `exe_en` with exe_op=1 and exe_data=3, one ack0, grant cleared after rdy returns, rr_ptr=1.
- All three requesters request continuously with 1-word bursts → grant order 0, 1, 2, 0, 1, 2; each ack appears exactly once per `exe_en`.
- Burst lock: req1 sends 4 words (last only on word 4) while req0 and req2 request → all four req1 words are issued consecutively before any other grant, then req2 is granted.
- Fast executor: `exe_rdy` never drops → WAIT_LOW exits after LOW_WAIT=4 cycles and the next word issues; no hang.
- Lock timeout: req2 sends a word with last=0 then drops `req`, with LOCK_TO=16 → release after 16 idle cycles, `err`=1, req0 is granted next.
- Reset mid-WAIT_HIGH → all outputs return to their reset values immediately; after release the pending req0 is re-arbitrated from rr_ptr=0.
